frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter WIDTH, default 768, image width in pixels; even, >= 2.
REQ-002 Parameter HEIGHT, default 512, image height in rows; >= 1.
REQ-003 Parameter START_UP_DELAY, default 100, vertical-pulse length in cycles; >= 1.
REQ-004 Parameter HSYNC_DELAY, default 160, inter-row blanking in cycles; >= 1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  frame request, sampled at a rising edge in IDLE.
REQ-008 abort  input  1  terminates the current frame.
REQ-009 stall  input  1  downstream backpressure; honoured only in DATA.
REQ-010 vertical_Pulse  output  1  high throughout VSYNC.
REQ-011 horizontal_Pulse  output  1  high in DATA cycles that issue a pixel pair.
REQ-012 ctrl_data_run  output  1  equals horizontal_Pulse; datapath read enable.
REQ-013 row  output  16  current row index, 0..HEIGHT-1.
REQ-014 col  output  16  current even column index, 0..WIDTH-2, step 2.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 sig_done  output  1  one-cycle pulse on frame completion.
REQ-017 frame_count  output  8  completed-frame counter; wraps 255 -> 0.

Function
REQ-018 All outputs SHALL be registered; FSM states are IDLE, VSYNC, HSYNC, DATA.
REQ-019 IDLE: start=1 and abort=0 at an edge SHALL enter VSYNC, load row=0, col=0, clear the delay counter.
REQ-020 VSYNC SHALL last exactly START_UP_DELAY cycles with vertical_Pulse=1, then enter HSYNC.
REQ-021 HSYNC SHALL last exactly HSYNC_DELAY cycles with both pulses low, then enter DATA.
REQ-022 DATA with stall=0: horizontal_Pulse=1 and the pair (row, col) is issued; col advances by 2 at the next edge.
REQ-023 DATA with stall=1: horizontal_Pulse=0; row, col, and state SHALL hold.
REQ-024 Issuing col=WIDTH-2 with row<HEIGHT-1 SHALL set col=0, increment row, and enter HSYNC.
REQ-025 Issuing col=WIDTH-2 with row=HEIGHT-1 SHALL enter IDLE and, in the following cycle only, assert sig_done=1 and increment frame_count.
REQ-026 Unstalled frame length from the first VSYNC cycle to the last issue cycle SHALL be START_UP_DELAY + HEIGHT*(HSYNC_DELAY + WIDTH/2) cycles.
REQ-027 start while busy SHALL be ignored, with no queuing.
REQ-028 abort=1 in any non-IDLE state SHALL enter IDLE at the next edge, with pulses low and no sig_done or frame_count change.
REQ-029 abort and start high together in IDLE: abort wins and the block stays in IDLE.
REQ-030 abort coinciding with the final issue SHALL take precedence, with no sig_done.
REQ-031 start asserted in the same cycle as sig_done SHALL be accepted, because the state is IDLE.
REQ-032 row and col SHALL retain their last values in IDLE.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, with all outputs and internal counters at 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame without asserting sig_done.
REQ-035 After reset deassertion, the block SHALL stay in IDLE until a qualifying start.

Verification (WIDTH=8, HEIGHT=2, START_UP_DELAY=3, HSYNC_DELAY=2)
REQ-036 Single start pulse, no stall -> vertical_Pulse high for 3 cycles; 2 blank cycles; 4 issues with col 0,2,4,6 at row 0; 2 blank cycles; 4 issues at row 1; sig_done one cycle later; frame_count=1; total 15 cycles.
REQ-037 stall=1 for 3 cycles while issuing row 0, col 4 -> col holds at 4 and horizontal_Pulse is low for those 3 cycles; frame completes 3 cycles late.
REQ-038 abort during row 1, col 2 -> IDLE next cycle, busy=0, sig_done never asserts, frame_count unchanged.
REQ-039 start pulsed during DATA -> ignored, and exactly one sig_done occurs.
REQ-040 reset low mid-HSYNC -> all outputs 0 asynchronously; a start after release produces a full 15-cycle frame.
REQ-041 256 back-to-back frames, each started in its sig_done cycle -> frame_count wraps to 0, with no idle gaps beyond one cycle.

Source files
------------

// File: rtl/frame_sequencer.sv
// Raster frame sequencer: vertical pulse, per-row blanking, then one pixel-pair
// issue per unstalled DATA cycle. Every output is driven straight from a register.
module frame_sequencer #(
  parameter int unsigned WIDTH          = 768,
  parameter int unsigned HEIGHT         = 512,
  parameter int unsigned START_UP_DELAY = 100,
  parameter int unsigned HSYNC_DELAY    = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        stall,
  output logic        vertical_Pulse,
  output logic        horizontal_Pulse,
  output logic        ctrl_data_run,
  output logic [15:0] row,
  output logic [15:0] col,
  output logic        busy,
  output logic        sig_done,
  output logic [7:0]  frame_count
);

  localparam int unsigned DMAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int unsigned CW   = (DMAX > 1) ? $clog2(DMAX) : 1;

  localparam logic [CW-1:0] VS_LAST  = CW'(START_UP_DELAY - 1);
  localparam logic [CW-1:0] HS_LAST  = CW'(HSYNC_DELAY - 1);
  localparam logic [15:0]   LAST_COL = 16'(WIDTH - 2);
  localparam logic [15:0]   LAST_ROW = 16'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    VSYNC,
    HSYNC,
    DATA
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [15:0]   row_q,   row_d;
  logic [15:0]   col_q,   col_d;
  logic          vp_q,    vp_d;
  logic          hp_q,    hp_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic [7:0]    fc_q,    fc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    vp_d    = 1'b0;
    hp_d    = 1'b0;
    done_d  = 1'b0;
    fc_d    = fc_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = VSYNC;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          vp_d    = 1'b1;
        end
      end
      VSYNC: begin
        if (cnt_q == VS_LAST) begin
          state_d = HSYNC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          vp_d  = 1'b1;
        end
      end
      HSYNC: begin
        if (cnt_q == HS_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          hp_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        // hp_q marks the current cycle as an issue; stall seen here gates the next cycle's issue.
        if (hp_q) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              state_d = IDLE;
              col_d   = col_q;
              done_d  = 1'b1;
              fc_d    = fc_q + 8'd1;
            end else begin
              state_d = HSYNC;
              row_d   = row_q + 16'd1;
              cnt_d   = '0;
            end
          end else begin
            col_d = col_q + 16'd2;
            hp_d  = !stall;
          end
        end else begin
          hp_d = !stall;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      row_d   = row_q;
      col_d   = col_q;
      vp_d    = 1'b0;
      hp_d    = 1'b0;
      done_d  = 1'b0;
      fc_d    = fc_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      vp_q    <= 1'b0;
      hp_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      vp_q    <= vp_d;
      hp_q    <= hp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fc_q    <= fc_d;
    end
  end

  assign vertical_Pulse   = vp_q;
  assign horizontal_Pulse = hp_q;
  assign ctrl_data_run    = hp_q;
  assign row              = row_q;
  assign col              = col_q;
  assign busy             = busy_q;
  assign sig_done         = done_q;
  assign frame_count      = fc_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: fixed vector table, directed corner sequences, and
// random traffic checked against a queue-based frame schedule model.
module tb_frame_sequencer;

  localparam int W   = 8;
  localparam int HT  = 2;
  localparam int SUD = 3;
  localparam int HSD = 2;
  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;

  logic        clk, reset, start, abort, stall;
  logic        vp, hp, cdr, busy, done;
  logic [15:0] row, col;
  logic [7:0]  fc;

  frame_sequencer #(
    .WIDTH(W), .HEIGHT(HT), .START_UP_DELAY(SUD), .HSYNC_DELAY(HSD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .stall(stall),
    .vertical_Pulse(vp), .horizontal_Pulse(hp), .ctrl_data_run(cdr),
    .row(row), .col(col), .busy(busy), .sig_done(done), .frame_count(fc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs; the model replays a precomputed frame schedule.
  typedef struct packed {
    logic        vp, hp;
    logic [15:0] row, col;
    logic        busy, done;
    logic [7:0]  fc;
    logic        indata;
  } rec_t;

  rec_t cur;
  rec_t q[$];

  function automatic rec_t mkrec(logic v, logic h, int r, int c, logic b, logic d,
                                 logic [7:0] f, logic ind);
    rec_t x;
    x.vp = v; x.hp = h; x.row = 16'(r); x.col = 16'(c);
    x.busy = b; x.done = d; x.fc = f; x.indata = ind;
    return x;
  endfunction

  task automatic build_frame(input logic [7:0] f);
    q.delete();
    for (int unsigned v = 0; v < SUD; v++) q.push_back(mkrec(L1, L0, 0, 0, L1, L0, f, L0));
    for (int unsigned r = 0; r < HT; r++) begin
      for (int unsigned h = 0; h < HSD; h++) q.push_back(mkrec(L0, L0, int'(r), 0, L1, L0, f, L0));
      for (int unsigned c = 0; c < W / 2; c++)
        q.push_back(mkrec(L0, L1, int'(r), int'(2 * c), L1, L0, f, L1));
    end
    q.push_back(mkrec(L0, L0, HT - 1, W - 2, L0, L1, f + 8'd1, L0));
  endtask

  task automatic model_step(input logic s, input logic a, input logic st);
    rec_t nx;
    if (!cur.busy) begin
      if (s && !a) begin
        build_frame(cur.fc);
        cur = q.pop_front();
      end else begin
        cur.vp = 0; cur.hp = 0; cur.done = 0; cur.indata = 0;
      end
    end else if (a) begin
      q.delete();
      cur.vp = 0; cur.hp = 0; cur.busy = 0; cur.done = 0; cur.indata = 0;
    end else if (st && cur.indata && q.size() > 0 && q[0].hp) begin
      nx = q[0];
      nx.hp = 0;
      cur = nx;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end
  endtask

  task automatic compare_model();
    chk("vertical_Pulse", vp, cur.vp);
    chk("horizontal_Pulse", hp, cur.hp);
    chk("ctrl_data_run", cdr, cur.hp);
    chk("row", row, cur.row);
    chk("col", col, cur.col);
    chk("busy", busy, cur.busy);
    chk("sig_done", done, cur.done);
    chk("frame_count", fc, cur.fc);
  endtask

  task automatic step(input logic s, input logic a, input logic st);
    start = s; abort = a; stall = st;
    @(posedge clk);
    model_step(s, a, st);
    #1 compare_model();
  endtask

  task automatic apply_reset();
    start = 0; abort = 0; stall = 0;
    #2 reset = 0;
    #1;
    cur = '0;
    q.delete();
    chk("async_reset_vp", vp, 0);
    chk("async_reset_hp", hp, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_row", row, 0);
    chk("async_reset_col", col, 0);
    chk("async_reset_fc", fc, 0);
    chk("async_reset_done", done, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1;
    compare_model();
  endtask

  typedef struct packed {
    logic        start, abort, stall;
    logic        vp, hp;
    logic [15:0] row, col;
    logic        busy, done;
    logic [7:0]  fc;
  } vec_t;

  function automatic vec_t mkv(logic s, logic a, logic st, logic v, logic h,
                               int r, int c, logic b, logic d, int f);
    vec_t x;
    x.start = s; x.abort = a; x.stall = st; x.vp = v; x.hp = h;
    x.row = 16'(r); x.col = 16'(c); x.busy = b; x.done = d; x.fc = 8'(f);
    return x;
  endfunction

  vec_t tbl[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, done_at, busycnt, gap, maxgap;
    logic [7:0] fc0;
    logic saw255;

    clk = 0; reset = 0; start = 0; abort = 0; stall = 0;
    cur = '0;

    // start+abort together, then one unstalled frame (15 busy cycles, done on cycle 16)
    tbl[0]  = mkv(L1, L1, L0, L0, L0, 0, 0, L0, L0, 0);
    tbl[1]  = mkv(L1, L0, L0, L1, L0, 0, 0, L1, L0, 0);
    tbl[2]  = mkv(L0, L0, L0, L1, L0, 0, 0, L1, L0, 0);
    tbl[3]  = mkv(L0, L0, L0, L1, L0, 0, 0, L1, L0, 0);
    tbl[4]  = mkv(L0, L0, L0, L0, L0, 0, 0, L1, L0, 0);
    tbl[5]  = mkv(L0, L0, L0, L0, L0, 0, 0, L1, L0, 0);
    tbl[6]  = mkv(L0, L0, L0, L0, L1, 0, 0, L1, L0, 0);
    tbl[7]  = mkv(L0, L0, L0, L0, L1, 0, 2, L1, L0, 0);
    tbl[8]  = mkv(L0, L0, L0, L0, L1, 0, 4, L1, L0, 0);
    tbl[9]  = mkv(L0, L0, L0, L0, L1, 0, 6, L1, L0, 0);
    tbl[10] = mkv(L0, L0, L0, L0, L0, 1, 0, L1, L0, 0);
    tbl[11] = mkv(L0, L0, L0, L0, L0, 1, 0, L1, L0, 0);
    tbl[12] = mkv(L0, L0, L0, L0, L1, 1, 0, L1, L0, 0);
    tbl[13] = mkv(L0, L0, L0, L0, L1, 1, 2, L1, L0, 0);
    tbl[14] = mkv(L0, L0, L0, L0, L1, 1, 4, L1, L0, 0);
    tbl[15] = mkv(L0, L0, L0, L0, L1, 1, 6, L1, L0, 0);
    tbl[16] = mkv(L0, L0, L0, L0, L0, 1, 6, L0, L1, 1);
    tbl[17] = mkv(L0, L0, L0, L0, L0, 1, 6, L0, L0, 1);

    #3;
    chk("reset_busy", busy, 0);
    chk("reset_vp", vp, 0);
    chk("reset_fc", fc, 0);
    chk("reset_row", row, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1;

    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("idle_after_reset", busy, 0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].start, tbl[i].abort, tbl[i].stall);
      chk($sformatf("tbl%0d_vp", i), vp, tbl[i].vp);
      chk($sformatf("tbl%0d_hp", i), hp, tbl[i].hp);
      chk($sformatf("tbl%0d_row", i), row, tbl[i].row);
      chk($sformatf("tbl%0d_col", i), col, tbl[i].col);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
      chk($sformatf("tbl%0d_fc", i), fc, tbl[i].fc);
    end

    // stall through three cycles at row 0 col 4
    step(1, 0, 0);
    done_at = 0;
    for (int k = 1; k <= 21; k++) begin
      step(0, 0, (k >= 7 && k <= 9));
      if (k + 1 >= 8 && k + 1 <= 10) begin
        chk("stall_col", col, 4);
        chk("stall_hp", hp, 0);
      end
      if (done === 1'b1) done_at = k + 1;
    end
    chk("stall_done_cycle", done_at, 19);

    // abort at row 1 col 2
    fc0 = fc;
    step(1, 0, 0);
    for (int k = 1; k <= 12; k++) step(0, 0, 0);
    chk("abort_pos_row", row, 1);
    chk("abort_pos_col", col, 2);
    step(0, 1, 0);
    chk("abort_busy", busy, 0);
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_fc", fc, fc0);

    // abort on the final issue cycle
    fc0 = fc;
    ndone = 0;
    step(1, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      step(0, (k == 14), 0);
      if (done === 1'b1) ndone++;
    end
    chk("abort_final_done", ndone, 0);
    chk("abort_final_fc", fc, fc0);

    // start pulses while busy are ignored
    ndone = 0;
    step(1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step((k == 7 || k == 12), 0, 0);
      if (done === 1'b1) ndone++;
    end
    chk("busy_start_dones", ndone, 1);

    // reset in the middle of HSYNC, then a full frame
    step(1, 0, 0);
    for (int k = 1; k <= 3; k++) step(0, 0, 0);
    chk("pre_reset_busy", busy, 1);
    apply_reset();
    ndone = 0; busycnt = 0;
    step(1, 0, 0);
    if (busy === 1'b1) busycnt++;
    for (int k = 1; k <= 18; k++) begin
      step(0, 0, 0);
      if (busy === 1'b1) busycnt++;
      if (done === 1'b1) ndone++;
    end
    chk("post_reset_len", busycnt, 15);
    chk("post_reset_dones", ndone, 1);
    chk("post_reset_fc", fc, 1);

    // 256 back-to-back frames with start held high
    apply_reset();
    ndone = 0; gap = 0; maxgap = 0; saw255 = 0;
    for (int k = 0; k < 256 * 16; k++) begin
      step(1, 0, 0);
      if (done === 1'b1) ndone++;
      if (fc === 8'd255) saw255 = 1;
      if (busy === 1'b1) gap = 0;
      else begin
        gap++;
        if (gap > maxgap) maxgap = gap;
      end
    end
    chk("b2b_dones", ndone, 256);
    chk("b2b_fc_wrap", fc, 0);
    chk("b2b_saw255", saw255, 1);
    chk("b2b_max_gap", maxgap, 1);
    step(0, 0, 0);

    // random traffic against the schedule model
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(5) == 0), ($urandom_range(39) == 0), ($urandom_range(2) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
